led_pipe_gen: RTL

LED_PIPE_GEN -- requirements
Module: led_pipe_gen

---
 rtl/led_pipe_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/led_pipe_gen.sv
// LED pattern generator: a prescaled step engine that rotates, bounces or holds
// a WIDTH-bit diode pattern, with registered step/wrap pulses per update.
module led_pipe_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] diode,
    output logic             step,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diode_q, diode_d;
    dir_e             dir_q, dir_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        cnt_d   = cnt_q;
        diode_d = diode_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        // >= compare so a lowered div fires on the next enabled cycle
        tick    = enable && (cnt_q >= div);

        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end

        if (tick) begin
            case (mode_sel)
                MODE_ROL: begin
                    diode_d = {diode_q[WIDTH-2:0], diode_q[WIDTH-1]};
                    step_d  = 1'b1;
                    wrap_d  = diode_q[WIDTH-1];
                end
                MODE_ROR: begin
                    diode_d = {diode_q[0], diode_q[WIDTH-1:1]};
                    step_d  = 1'b1;
                    wrap_d  = diode_q[0];
                end
                MODE_BOUNCE: begin
                    step_d = 1'b1;
                    if (diode_q == '0) begin
                        diode_d = diode_q;
                    end else if (dir_q == DIR_LEFT) begin
                        if (diode_q[WIDTH-1]) begin
                            dir_d   = DIR_RIGHT;
                            diode_d = diode_q >> 1;
                            wrap_d  = 1'b1;
                        end else begin
                            diode_d = diode_q << 1;
                        end
                    end else begin
                        if (diode_q[0]) begin
                            dir_d   = DIR_LEFT;
                            diode_d = diode_q << 1;
                            wrap_d  = 1'b1;
                        end else begin
                            diode_d = diode_q >> 1;
                        end
                    end
                end
                MODE_HOLD: begin
                    diode_d = diode_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            diode_q <= WIDTH'(1);
            dir_q   <= DIR_LEFT;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (load) begin
            cnt_q   <= '0;
            diode_q <= pattern;
            dir_q   <= DIR_LEFT;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            diode_q <= diode_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign diode = diode_q;
    assign step  = step_q;
    assign wrap  = wrap_q;

endmodule
